// File: rtl/wb_manager_interface.sv
// Single-outstanding Wishbone B4 pipelined manager: one local command in, one bus
// cycle out, one response back (read data or timeout error).
`timescale 1ns/1ps

module wb_manager_interface #(
  parameter int WB_ADDRESS_WIDTH    = 32,
  parameter int WB_DATA_WIDTH       = 32,
  parameter int WB_DATA_GRANULARITY = 8,
  parameter int TIMEOUT_CYCLES      = 64,
  localparam int SELECT_WIDTH       = WB_DATA_WIDTH / WB_DATA_GRANULARITY
) (
  input  logic                        i_wb_clk,
  input  logic                        i_wb_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_we,
  input  logic [WB_ADDRESS_WIDTH-1:0] i_cmd_addr,
  input  logic [WB_DATA_WIDTH-1:0]    i_cmd_wdata,
  input  logic [SELECT_WIDTH-1:0]     i_cmd_sel,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]    o_rsp_rdata,
  output logic                        o_rsp_err,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [WB_ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [WB_DATA_WIDTH-1:0]    o_wb_dat,
  output logic [SELECT_WIDTH-1:0]     o_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]    i_wb_dat,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                      state_q, state_d;
  logic                        cyc_q, cyc_d;
  logic                        stb_q, stb_d;
  logic                        we_q, we_d;
  logic [WB_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0]    dat_q, dat_d;
  logic [SELECT_WIDTH-1:0]     sel_q, sel_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic ack_hit;
  logic expired;

  // A stalled request cannot be acknowledged; in WAIT any ack completes the cycle.
  assign ack_hit = ((state_q == S_REQ) && !i_wb_stall && i_wb_ack) ||
                   ((state_q == S_WAIT) && i_wb_ack);
  assign expired = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          state_d = S_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          dat_d   = i_cmd_wdata;
          sel_d   = i_cmd_sel;
          cnt_d   = '0;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_hit) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? '0 : i_wb_dat;
          err_d       = 1'b0;
        end else if (expired) begin
          // An ack in the expiry cycle is handled above and takes priority.
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
        end else if ((state_q == S_REQ) && !i_wb_stall) begin
          state_d = S_WAIT;
          stb_d   = 1'b0;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_wb_manager_interface.sv
// Bench for wb_manager_interface: transaction-level timeline model, per-cycle compare.
`timescale 1ns/1ps

module tb_wb_manager_interface;

  localparam int TO    = 8;
  localparam int MAXN  = 2048;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0, i_cmd_we = 1'b0;
  logic [31:0] i_cmd_addr = '0, i_cmd_wdata = '0;
  logic [3:0]  i_cmd_sel = '0;
  logic        i_rsp_ready = 1'b0, i_wb_stall = 1'b0, i_wb_ack = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_rsp_rdata, o_wb_addr, o_wb_dat;
  logic [3:0]  o_wb_sel;

  always #5 clk = ~clk;

  wb_manager_interface #(
    .WB_ADDRESS_WIDTH(32), .WB_DATA_WIDTH(32), .WB_DATA_GRANULARITY(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_dat(i_wb_dat), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack)
  );

  // One command plus the subordinate/consumer behaviour scripted for it.
  // s = stall cycles, d = cycles from request acceptance to ack (0 = same cycle, NEVER = no ack),
  // r = cycles rsp_ready is held low, g = idle gap, pre = valid already high during previous response.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          s, d, r, g;
    bit          pre, fdat_en, late_ack;
    logic [31:0] fdat;
  } cmd_t;

  cmd_t cmds[$];

  bit          in_cv[MAXN], in_we[MAXN], in_stall[MAXN], in_ack[MAXN], in_rr[MAXN];
  logic [31:0] in_addr[MAXN], in_wdata[MAXN], in_dat[MAXN];
  logic [3:0]  in_sel[MAXN];
  bit          e_ready[MAXN], e_cyc[MAXN], e_stb[MAXN], e_rv[MAXN], e_err[MAXN], e_we[MAXN];
  logic [31:0] e_addr[MAXN], e_dat[MAXN], e_rdata[MAXN];
  logic [3:0]  e_sel[MAXN];

  int seg_len, cur, mode, seg, seg_ncmds;
  int vectors = 0, miscompares = 0;

  function automatic cmd_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] sel, input int s, input int d, input int r,
                              input int g, input bit pre);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.sel = sel;
    c.s = s; c.d = d; c.r = r; c.g = g; c.pre = pre;
    c.fdat_en = 1'b0; c.late_ack = 1'b0; c.fdat = '0;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    int s, d, r, g;
    bit pre;
    s   = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
    d   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 6);
    r   = $urandom_range(0, 3);
    pre = ($urandom_range(0, 2) == 0);
    g   = pre ? 0 : $urandom_range(0, 2);
    return mk(1'($urandom), $urandom, $urandom, 4'($urandom), s, d, r, g, pre);
  endfunction

  task automatic set_cmd(input int n, input cmd_t c);
    in_cv[n] = 1'b1; in_we[n] = c.we; in_addr[n] = c.addr;
    in_wdata[n] = c.wdata; in_sel[n] = c.sel;
  endtask

  task automatic set_bus(input int n, input bit we, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [3:0] sel);
    e_we[n] = we; e_addr[n] = addr; e_dat[n] = dat; e_sel[n] = sel;
  endtask

  // Lay the command list onto an absolute cycle timeline: stimulus and expected outputs.
  task automatic build();
    int pos, t, a, k, lst, rs, prev_rs;
    bit normal, pwe;
    logic [31:0] paddr, pdat;
    logic [3:0] psel;
    for (int n = 0; n < MAXN; n++) begin
      in_cv[n] = 1'($urandom); in_we[n] = 1'($urandom); in_addr[n] = $urandom;
      in_wdata[n] = $urandom; in_sel[n] = 4'($urandom); in_stall[n] = 1'($urandom);
      in_ack[n] = ($urandom_range(0, 3) == 0); in_dat[n] = $urandom; in_rr[n] = 1'($urandom);
      e_ready[n] = 1'b1; e_cyc[n] = 1'b0; e_stb[n] = 1'b0; e_rv[n] = 1'b0;
      e_rdata[n] = '0; e_err[n] = 1'b0;
    end
    pos = 0; prev_rs = -1; pwe = 1'b0; paddr = '0; pdat = '0; psel = '0;
    for (int ci = 0; ci < cmds.size(); ci++) begin
      cmd_t c;
      c = cmds[ci];
      t = pos + c.g;
      for (int n = pos; n < t; n++) in_cv[n] = 1'b0;
      if (c.pre && prev_rs >= 0)
        for (int n = prev_rs; n < t; n++) set_cmd(n, c);
      set_cmd(t, c);
      for (int n = pos; n <= t; n++) set_bus(n, pwe, paddr, pdat, psel);
      a      = t + 1;
      k      = (c.d == NEVER) ? NEVER : c.s + c.d;
      normal = (k <= TO - 1);
      lst    = normal ? k : TO - 1;
      for (int i = 0; i <= lst; i++) begin
        e_ready[a+i] = 1'b0; e_cyc[a+i] = 1'b1; e_stb[a+i] = (i <= c.s);
        in_ack[a+i] = normal && (i == k);
        if (i <= c.s) in_stall[a+i] = (i < c.s);
        set_bus(a + i, c.we, c.addr, c.wdata, c.sel);
      end
      if (normal && c.fdat_en) in_dat[a+k] = c.fdat;
      rs = a + lst + 1;
      for (int j = 0; j <= c.r; j++) begin
        e_ready[rs+j] = 1'b0; e_rv[rs+j] = 1'b1;
        e_rdata[rs+j] = (normal && !c.we) ? in_dat[a+k] : 32'h0;
        e_err[rs+j]   = !normal;
        in_rr[rs+j]   = (j == c.r);
        set_bus(rs + j, c.we, c.addr, c.wdata, c.sel);
      end
      if (c.late_ack) in_ack[a+lst+2] = 1'b1;
      prev_rs = rs;
      pos = rs + c.r + 1;
      pwe = c.we; paddr = c.addr; pdat = c.wdata; psel = c.sel;
    end
    for (int n = pos; n < pos + 6; n++) begin
      in_cv[n] = 1'b0;
      set_bus(n, pwe, paddr, pdat, psel);
    end
    seg_len   = pos + 6;
    seg_ncmds = cmds.size();
  endtask

  task automatic drive(input int n);
    i_cmd_valid = in_cv[n]; i_cmd_we = in_we[n]; i_cmd_addr = in_addr[n];
    i_cmd_wdata = in_wdata[n]; i_cmd_sel = in_sel[n]; i_wb_stall = in_stall[n];
    i_wb_ack = in_ack[n]; i_wb_dat = in_dat[n]; i_rsp_ready = in_rr[n];
  endtask

  task automatic drive_idle();
    i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_sel = '0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_dat = '0; i_rsp_ready = 1'b0;
  endtask

  task automatic play(input int len);
    seg++;
    mode = 1;
    for (int n = 0; n < len; n++) begin
      @(posedge clk); #1;
      cur = n;
      drive(n);
    end
    @(negedge clk); #1;
    mode = 0;
  endtask

  // Reset asserted just after a rising edge; reset values checked on the following falling edge.
  task automatic reset_and_release();
    @(posedge clk); #2;
    rst_n = 1'b0;
    drive_idle();
    mode = 2;
    @(negedge clk); #1;
    mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cur, act, exp);
    end
  endtask

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Compare process: every checked value in the run goes through here.
  initial begin : compare
    logic [63:0] obs_cyc[$], obs_stb[$], obs_rdata[$], obs_err[$], obs_rvlen[$];
    int seg_seen = 0, cc = 0, sc = 0, rl = 0;
    bit prev_cyc = 1'b0, prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin
          if (seg != seg_seen) begin
            obs_cyc.delete(); obs_stb.delete(); obs_rdata.delete();
            obs_err.delete(); obs_rvlen.delete();
            prev_cyc = 1'b0; prev_rv = 1'b0; seg_seen = seg;
          end
          check("cmd_ready", o_cmd_ready, e_ready[cur]);
          check("wb_cyc",    o_wb_cyc,    e_cyc[cur]);
          check("wb_stb",    o_wb_stb,    e_stb[cur]);
          check("wb_we",     o_wb_we,     e_we[cur]);
          check("wb_addr",   o_wb_addr,   e_addr[cur]);
          check("wb_dat",    o_wb_dat,    e_dat[cur]);
          check("wb_sel",    o_wb_sel,    e_sel[cur]);
          check("rsp_valid", o_rsp_valid, e_rv[cur]);
          if (e_rv[cur]) begin
            check("rsp_rdata", o_rsp_rdata, e_rdata[cur]);
            check("rsp_err",   o_rsp_err,   e_err[cur]);
          end
          if (o_wb_cyc) begin
            if (!prev_cyc) begin cc = 0; sc = 0; end
            cc++;
            if (o_wb_stb) sc++;
          end else if (prev_cyc) begin
            obs_cyc.push_back(64'(cc)); obs_stb.push_back(64'(sc));
          end
          if (o_rsp_valid) begin
            if (!prev_rv) begin
              obs_rdata.push_back(64'(o_rsp_rdata)); obs_err.push_back(64'(o_rsp_err)); rl = 0;
            end
            rl++;
          end else if (prev_rv) begin
            obs_rvlen.push_back(64'(rl));
          end
          prev_cyc = o_wb_cyc; prev_rv = o_rsp_valid;
        end
        2: begin
          check("rst_cyc",   o_wb_cyc,    0);
          check("rst_stb",   o_wb_stb,    0);
          check("rst_we",    o_wb_we,     0);
          check("rst_addr",  o_wb_addr,   0);
          check("rst_dat",   o_wb_dat,    0);
          check("rst_sel",   o_wb_sel,    0);
          check("rst_rv",    o_rsp_valid, 0);
          check("rst_rdata", o_rsp_rdata, 0);
          check("rst_err",   o_rsp_err,   0);
        end
        3: begin
          check("rsp_count",    64'(obs_rdata.size()), 64'(seg_ncmds));
          check("rd_stb_len",   qget(obs_stb, 0),   1);
          check("rd_cyc_len",   qget(obs_cyc, 0),   2);
          check("rd_rdata",     qget(obs_rdata, 0), 64'h0001_0203);
          check("rd_err",       qget(obs_err, 0),   0);
          check("wr_stb_len",   qget(obs_stb, 1),   4);
          check("wr_cyc_len",   qget(obs_cyc, 1),   5);
          check("wr_rdata",     qget(obs_rdata, 1), 0);
          check("wr_err",       qget(obs_err, 1),   0);
          check("to_cyc_len",   qget(obs_cyc, 2),   8);
          check("to_err",       qget(obs_err, 2),   1);
          check("to_rdata",     qget(obs_rdata, 2), 0);
          check("bp_rv_len",    qget(obs_rvlen, 3), 6);
          check("comb_cyc_len", qget(obs_cyc, 4),   1);
          check("comb_stb_len", qget(obs_stb, 4),   1);
        end
        4: begin
          check("post_rst_count", 64'(obs_rdata.size()), 64'(seg_ncmds));
          check("post_rst_rdata", qget(obs_rdata, 0), 64'h1234_5678);
          check("post_rst_err",   qget(obs_err, 0),   0);
        end
        default: ;
      endcase
    end
  end

  initial begin : driver
    cmd_t c;
    mode = 0; cur = 0; seg = 0;

    // Test-plan scenarios followed by random traffic.
    reset_and_release();
    cmds.delete();
    c = mk(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 1, 0, 1, 1'b0);
    c.fdat_en = 1'b1; c.fdat = 32'h0001_0203;
    cmds.push_back(c);
    cmds.push_back(mk(1'b1, 32'h4000_0008, 32'hDEAD_BEEF, 4'h3, 3, 1, 0, 1, 1'b0));
    c = mk(1'b0, 32'h4000_0010, 32'h0, 4'hF, 0, NEVER, 2, 0, 1'b0);
    c.late_ack = 1'b1;
    cmds.push_back(c);
    cmds.push_back(mk(1'b0, 32'h4000_0014, 32'h0, 4'hF, 1, 2, 5, 1, 1'b0));
    cmds.push_back(mk(1'b0, 32'h4000_0018, 32'h0, 4'hC, 0, 0, 0, 0, 1'b1));
    for (int i = 0; i < 40; i++) cmds.push_back(rand_cmd());
    build();
    play(seg_len);
    mode = 3;
    @(negedge clk); #1;
    mode = 0;

    // Reset while the manager waits for an ack.
    reset_and_release();
    cmds.delete();
    cmds.push_back(mk(1'b0, 32'h4000_0020, 32'h0, 4'hF, 0, 5, 0, 1, 1'b0));
    build();
    play(5);
    reset_and_release();

    // Normal operation after the aborted transaction.
    cmds.delete();
    c = mk(1'b0, 32'h4000_0024, 32'h0, 4'hF, 0, 1, 0, 0, 1'b0);
    c.fdat_en = 1'b1; c.fdat = 32'h1234_5678;
    cmds.push_back(c);
    for (int i = 0; i < 40; i++) cmds.push_back(rand_cmd());
    build();
    play(seg_len);
    mode = 4;
    @(negedge clk); #1;
    mode = 0;

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_manager_interface.md
# wb_manager_interface

Single-outstanding Wishbone B4 pipelined manager. It accepts one command at a time from a local valid/ready port, runs the matching read or write cycle on the bus, and returns the read data or an error on a valid/ready response port. It is the initiator-side counterpart to the team's Wishbone subordinate interface. It is used by test sequencers, DMA control and CPU-less configuration engines to reach IP register maps.

## Interface
Parameters:
- WB_ADDRESS_WIDTH, 32, bus address width
- WB_DATA_WIDTH, 32, bus data width
- WB_DATA_GRANULARITY, 8, bits per select lane; SELECT_WIDTH = WB_DATA_WIDTH/WB_DATA_GRANULARITY
- TIMEOUT_CYCLES, 64, cycles from bus request to ack before abort; 0 disables the timeout

Ports:
- i_wb_clk  in  1  single clock, rising edge
- i_wb_rst_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_we  in  1  1=write, 0=read
- i_cmd_addr  in  WB_ADDRESS_WIDTH  byte address
- i_cmd_wdata  in  WB_DATA_WIDTH  write data
- i_cmd_sel  in  SELECT_WIDTH  byte-lane select
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_rdata  out  WB_DATA_WIDTH  read data (0 for writes and errors)
- o_rsp_err  out  1  1 = timeout abort
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone control
- o_wb_addr  out  WB_ADDRESS_WIDTH; o_wb_dat  out  WB_DATA_WIDTH; o_wb_sel  out  SELECT_WIDTH
- i_wb_dat  in  WB_DATA_WIDTH; i_wb_stall  in  1; i_wb_ack  in  1

## Operation
- States are IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from the state register.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, latch we/addr/wdata/sel into o_wb_we/o_wb_addr/o_wb_dat/o_wb_sel, clear the timeout counter and go to REQ.
- REQ:
  - cyc=1, stb=1.
  - If i_wb_stall=1: stay; bus outputs are held stable.
  - If i_wb_stall=0 and i_wb_ack=1: capture and go to RESP (combinational-ack subordinate).
  - If i_wb_stall=0 and i_wb_ack=0: go to WAIT; stb drops next cycle.
- WAIT:
  - cyc=1, stb=0.
  - On i_wb_ack: capture and go to RESP.
- Capture: o_rsp_rdata = i_wb_dat for reads, 0 for writes; o_rsp_err=0.
- Timeout:
  - The counter increments every cycle in REQ or WAIT. Width is $clog2(TIMEOUT_CYCLES+1).
  - When count==TIMEOUT_CYCLES-1 and there is no qualifying ack that cycle, go to RESP with err=1 and rdata=0. cyc and stb drop.
  - An ack arriving in the same cycle as expiry wins (normal response).
- RESP:
  - cyc=0, o_rsp_valid=1; rdata and err are held.
  - On i_rsp_ready, go to IDLE.
  - A command is not accepted in the same cycle the response is consumed.
- i_wb_ack outside REQ/WAIT, including a late ack after a timeout, is ignored.
- o_wb_addr, o_wb_dat, o_wb_sel and o_wb_we hold their last values when idle.

## Timing
- Reset values, applied immediately on i_wb_rst_n low independent of the clock:
  - state=IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat and o_wb_sel all 0.
  - o_rsp_valid, o_rsp_rdata and o_rsp_err all 0.
  - o_cmd_ready = 1 once out of reset.
- Reset asserted mid-transaction drops cyc asynchronously. The outstanding command is discarded and no response is issued.
- Latency with a registered-ack subordinate and no stall:
  - Command accepted at edge E0.
  - cyc/stb high after E0.
  - Request accepted at E1.
  - Ack sampled at E2.
  - o_rsp_valid high after E2.
- Each stall cycle adds 1 cycle.
- Throughput: one command per (latency + 1) cycles minimum, because RESP→IDLE costs a cycle.
- stb is high for exactly (stall cycles + 1) cycles per command.
- cyc falls the cycle after ack or timeout.

## Test plan
- Read, no stall:
  - cmd we=0, addr=0x4000_0000, sel=0xF; subordinate acks at E2 with dat=0x0001_0203.
  - Required: rsp_valid after E2, rdata=0x0001_0203, err=0, stb high 1 cycle.
- Write with stall:
  - cmd we=1, addr=0x4000_0008, wdata=0xDEAD_BEEF, sel=0x3; stall held 3 cycles.
  - Required: stb high 4 cycles with addr/dat/sel stable; response rdata=0, err=0.
- Timeout:
  - TIMEOUT_CYCLES=8, read with ack never asserted.
  - Required: cyc high exactly 8 cycles; rsp err=1, rdata=0.
  - A late ack 2 cycles after the timeout produces no second response.
- Response backpressure:
  - i_rsp_ready held low 5 cycles after rsp_valid.
  - Required: rdata/err stable, cmd_ready=0, cyc=0 throughout; cmd_ready rises the cycle after the handshake.
- Reset mid-cycle:
  - Assert i_wb_rst_n=0 while in WAIT.
  - Required: cyc/stb/rsp_valid low without a clock edge; after release, cmd_ready=1 and the next read completes normally.
- Combinational ack:
  - Subordinate asserts ack with stall=0 in the first stb cycle.
  - Required: direct REQ→RESP transition; rsp_valid one cycle after the request edge.
